// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The loader FSM and the UART receiver both draw their encodings from here.
package loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int COUNT_W = 16;
  localparam int ADDR_W  = 30;

  localparam logic [BYTE_W-1:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // States in which a frame is open: these are the only ones that time out or abort.
  function automatic logic in_frame(loader_state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-FF synchronizer, mid-bit sampling and glitch rejection.
// Emits one-cycle byte_valid or frame_err pulses at the middle of the stop bit.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_valid,
  output logic              o_frame_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t         r_state;
  rx_state_t         w_next_state;
  logic [1:0]        r_rx_sync;
  logic              r_rx_prev;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [BYTE_W-1:0] r_shift;
  logic              r_byte_valid;
  logic              r_frame_err;
  logic              w_rx;
  logic              w_fall;
  logic              w_bit_tick;
  logic              w_half_tick;

  assign w_rx        = r_rx_sync[1];
  assign w_fall      = r_rx_prev && !w_rx;
  assign w_bit_tick  = (r_clk_cnt == LAST_CNT);
  assign w_half_tick = (r_clk_cnt == HALF_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RX_IDLE;
    else       r_state <= w_next_state;
  end

  // A start bit that reads high again at its midpoint is treated as a glitch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next_state = RX_START;
      RX_START: if (w_half_tick) w_next_state = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_next_state = RX_STOP;
      RX_STOP:  if (w_bit_tick) w_next_state = RX_IDLE;
      default:  w_next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_sync    <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_sync    <= {r_rx_sync[0], i_rx};
      r_rx_prev    <= w_rx;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
        RX_START: r_clk_cnt <= w_half_tick ? '0 : r_clk_cnt + 1'b1;
        RX_DATA: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[BYTE_W-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_bit_tick) begin
            r_clk_cnt    <= '0;
            r_byte_valid <= w_rx;
            r_frame_err  <= !w_rx;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/program_loader.sv
// Receives a framed, XOR-checksummed program image over UART, writes it into memory
// word by word, and holds the core in reset until a verified image has landed.
module program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 1024,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_uart_rx,
  output logic               o_mem_wren,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [WORD_W-1:0]  o_mem_data,
  output logic               o_cpu_rst,
  output logic               o_busy,
  output logic               o_error,
  output logic [COUNT_W-1:0] o_words_loaded
);

  localparam int                 GAP_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [GAP_W-1:0]   GAP_LIMIT = GAP_W'(TIMEOUT_CLKS);
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_WORDS);

  loader_state_t      r_state;
  loader_state_t      w_next_state;
  logic [BYTE_W-1:0]  w_byte;
  logic               w_byte_valid;
  logic               w_frame_err;
  logic [BYTE_W-1:0]  r_count_lo;
  logic [COUNT_W-1:0] r_word_count;
  logic [COUNT_W-1:0] r_words_loaded;
  logic [BYTE_W-1:0]  r_csum;
  logic [1:0]         r_byte_idx;
  logic [23:0]        r_word;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_mem_wren;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [WORD_W-1:0]  r_mem_data;
  logic [COUNT_W-1:0] w_count;
  logic               w_hdr;
  logic               w_in_frame;
  logic               w_timeout;
  logic               w_abort;
  logic               w_last_byte;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_uart_rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  assign w_count     = {w_byte, r_count_lo};
  assign w_hdr       = w_byte_valid && (w_byte == HEADER_BYTE);
  assign w_in_frame  = in_frame(r_state);
  assign w_timeout   = w_in_frame && (r_gap_cnt == GAP_LIMIT);
  assign w_abort     = w_frame_err || w_timeout;
  assign w_last_byte = (r_byte_idx == 2'd3) && ((r_words_loaded + 16'd1) == r_word_count);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (w_hdr) w_next_state = ST_CNT_LO;
      ST_CNT_LO: begin
        if (w_abort)           w_next_state = ST_ERR;
        else if (w_byte_valid) w_next_state = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        if (w_abort)                  w_next_state = ST_ERR;
        else if (w_byte_valid) begin
          if (w_count > MAX_COUNT)    w_next_state = ST_ERR;
          else if (w_count == '0)     w_next_state = ST_CHECK;
          else                        w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_abort)                          w_next_state = ST_ERR;
        else if (w_byte_valid && w_last_byte) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_abort)           w_next_state = ST_ERR;
        else if (w_byte_valid) w_next_state = (w_byte == r_csum) ? ST_DONE : ST_ERR;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Words are assembled LSB-first; the 4th byte completes the word and fires the write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count_lo     <= '0;
      r_word_count   <= '0;
      r_words_loaded <= '0;
      r_csum         <= '0;
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_gap_cnt      <= '0;
      r_mem_wren     <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
    end else begin
      r_mem_wren <= 1'b0;
      if (!w_in_frame || w_byte_valid) r_gap_cnt <= '0;
      else                             r_gap_cnt <= r_gap_cnt + 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_hdr) begin
            r_words_loaded <= '0;
            r_csum         <= '0;
            r_byte_idx     <= '0;
          end
        end
        ST_CNT_LO: begin
          if (w_byte_valid) begin
            r_count_lo <= w_byte;
            r_csum     <= r_csum ^ w_byte;
          end
        end
        ST_CNT_HI: begin
          if (w_byte_valid) begin
            r_word_count <= w_count;
            r_csum       <= r_csum ^ w_byte;
          end
        end
        ST_DATA: begin
          if (w_byte_valid) begin
            r_csum     <= r_csum ^ w_byte;
            r_word     <= {w_byte, r_word[23:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_mem_wren     <= 1'b1;
              r_mem_addr     <= {{(ADDR_W - COUNT_W){1'b0}}, r_words_loaded};
              r_mem_data     <= {w_byte, r_word};
              r_words_loaded <= r_words_loaded + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_wren     = r_mem_wren;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_data     = r_mem_data;
  assign o_cpu_rst      = (r_state != ST_DONE);
  assign o_busy         = w_in_frame;
  assign o_error        = (r_state == ST_ERR);
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: drives UART frames bit by bit and compares memory
// writes and status outputs with a frame-level reference model.
module tb_program_loader;

  localparam int CPB     = 4;
  localparam int TIMEOUT = 200;
  localparam int MAXW    = 1024;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxLine;
  logic        memWren;
  logic [29:0] memAddr;
  logic [31:0] memData;
  logic        cpuRst;
  logic        busy;
  logic        error;
  logic [15:0] wordsLoaded;

  int checkCount = 0;
  int failCount  = 0;

  logic [61:0] obsQ[$];
  logic [61:0] expQ[$];
  logic [31:0] frameWords[16];

  program_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS   (MAXW),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_uart_rx     (rxLine),
    .o_mem_wren    (memWren),
    .o_mem_addr    (memAddr),
    .o_mem_data    (memData),
    .o_cpu_rst     (cpuRst),
    .o_busy        (busy),
    .o_error       (error),
    .o_words_loaded(wordsLoaded)
  );

  always #5 clk = ~clk;

  // Every write strobe seen by the memory port is captured for later comparison.
  always @(negedge clk) begin
    if (rst === 1'b0 && memWren === 1'b1) obsQ.push_back({memAddr, memData});
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit = 1'b1);
    @(negedge clk);
    rxLine = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxLine = stopBit;
    repeat (CPB) @(negedge clk);
    rxLine = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkWrites(input string tag);
    int n;
    checkOutput({tag, "_nwrites"}, 32'(obsQ.size()), 32'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_addr"}, 32'(obsQ[i][61:32]), 32'(expQ[i][61:32]));
      checkOutput({tag, "_data"}, obsQ[i][31:0], expQ[i][31:0]);
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic checkIdleState(input string tag, input logic expError, input logic expCpuRst);
    checkOutput({tag, "_error"}, 32'(error), 32'(expError));
    checkOutput({tag, "_cpu_rst"}, 32'(cpuRst), 32'(expCpuRst));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Frame-level model: builds the byte stream from frameWords, predicts every write
  // and the final outcome from the checksum rule alone.
  task automatic sendFrame(input string tag, input int n, input logic [7:0] sumFlip, input bit glitch);
    logic [15:0] cnt;
    logic [7:0]  sum;
    logic [7:0]  b;
    bit          good;
    cnt  = 16'(n);
    good = (sumFlip == 8'h00);
    applyStimulus(HDR);
    waitCycles(2);
    checkOutput({tag, "_hdr_cpu_rst"}, 32'(cpuRst), 32'd1);
    checkOutput({tag, "_hdr_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_hdr_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_hdr_words"}, 32'(wordsLoaded), 32'd0);
    sum = cnt[7:0] ^ cnt[15:8];
    applyStimulus(cnt[7:0]);
    applyStimulus(cnt[15:8]);
    if (glitch) begin
      waitCycles(3);
      rxLine = 1'b0;
      @(negedge clk);
      rxLine = 1'b1;
      waitCycles(10);
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = frameWords[w][8*k +: 8];
        sum ^= b;
        applyStimulus(b);
      end
      expQ.push_back({30'(w), frameWords[w]});
    end
    applyStimulus(sum ^ sumFlip);
    waitCycles(4);
    checkOutput({tag, "_words"}, 32'(wordsLoaded), 32'(n));
    checkIdleState(tag, !good, !good);
    checkWrites(tag);
  endtask

  task automatic sendNoise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == HDR) b = 8'h5A;
      applyStimulus(b);
    end
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    rxLine = 1'b1;
    waitCycles(3);
    checkOutput("rst_cpu_rst", 32'(cpuRst), 32'd1);
    checkOutput("rst_wren", 32'(memWren), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_data", memData, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words", 32'(wordsLoaded), 32'd0);
    rst = 1'b0;
    waitCycles(5);

    applyStimulus(8'h11);
    applyStimulus(8'h22);
    waitCycles(4);
    checkIdleState("noise", 1'b0, 1'b1);

    frameWords[0] = 32'h12345678;
    frameWords[1] = 32'hDEADBEEF;
    sendFrame("good", 2, 8'h00, 1'b1);
    sendFrame("badsum", 2, 8'h01, 1'b0);
    applyStimulus(8'h11);
    waitCycles(4);
    checkIdleState("err_noise", 1'b1, 1'b1);
    sendFrame("recover", 2, 8'h00, 1'b0);

    applyStimulus(HDR);
    applyStimulus(8'h01);
    applyStimulus(8'h04);
    waitCycles(4);
    checkIdleState("oversize", 1'b1, 1'b1);
    checkWrites("oversize");

    sendFrame("empty", 0, 8'h00, 1'b0);

    frameWords[0] = $urandom;
    sendFrame("reload", 1, 8'h00, 1'b0);

    applyStimulus(HDR);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55, 1'b0);
    waitCycles(4);
    checkIdleState("framing", 1'b1, 1'b1);
    checkOutput("framing_words", 32'(wordsLoaded), 32'd0);
    checkWrites("framing");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int w = 0; w < n; w++) frameWords[w] = $urandom;
      sendNoise($urandom_range(0, 2));
      sendFrame("rand", n, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                bit'($urandom_range(0, 1)));
    end

    frameWords[0] = $urandom;
    frameWords[1] = $urandom;
    applyStimulus(HDR);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    for (int k = 0; k < 5; k++) applyStimulus((k < 4) ? frameWords[0][8*k +: 8] : frameWords[1][7:0]);
    expQ.push_back({30'd0, frameWords[0]});
    waitCycles(150);
    checkOutput("timeout_early_error", 32'(error), 32'd0);
    checkOutput("timeout_early_busy", 32'(busy), 32'd1);
    waitCycles(80);
    checkIdleState("timeout", 1'b1, 1'b1);
    checkOutput("timeout_words", 32'(wordsLoaded), 32'd1);
    checkWrites("timeout");

    sendFrame("pre_rst", 1, 8'h00, 1'b0);
    frameWords[0] = $urandom;
    applyStimulus(HDR);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    for (int k = 0; k < 5; k++) applyStimulus((k < 4) ? frameWords[0][8*k +: 8] : 8'h9C);
    expQ.push_back({30'd0, frameWords[0]});
    checkWrites("mid_rst");
    checkOutput("mid_rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_cpu_rst", 32'(cpuRst), 32'd1);
    checkOutput("mid_rst_wren", 32'(memWren), 32'd0);
    checkOutput("mid_rst_addr", 32'(memAddr), 32'd0);
    checkOutput("mid_rst_data", memData, 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_error", 32'(error), 32'd0);
    checkOutput("mid_rst_words", 32'(wordsLoaded), 32'd0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
